test_rd_ctrl_check_64bit: RTL and testbench

//  AXI read initiator + self-checker for the DDR3 test path. Issues one INCR burst per read_en,

---
 rtl/test_rd_ctrl_check_64bit_if.sv | 32 +++
 rtl/test_rd_ctrl_check_64bit.sv | 210 +++++++++++++++++++++
 tb/tb_test_rd_ctrl_check_64bit.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/test_rd_ctrl_check_64bit_if.sv
// AXI read-channel bundle (AR + R) between the DDR3 test read checker and the memory side.
// Handshake: a transfer happens on a rising clk edge where valid && ready; the valid side
// holds its payload stable while valid is high and ready may change freely.
interface test_rd_ctrl_check_64bit_if;
  logic [31:0] axi_araddr;
  logic [7:0]  axi_arid;
  logic [7:0]  axi_arlen;
  logic [2:0]  axi_arsize;
  logic [1:0]  axi_arburst;
  logic        axi_arlock;
  logic [3:0]  axi_arqos;
  logic        axi_arvalid;
  logic        axi_arready;
  logic [63:0] axi_rdata;
  logic [7:0]  axi_rid;
  logic [1:0]  axi_rresp;
  logic        axi_rlast;
  logic        axi_rvalid;
  logic        axi_rready;

  modport master (
    output axi_araddr, axi_arid, axi_arlen, axi_arsize, axi_arburst, axi_arlock, axi_arqos,
    output axi_arvalid, axi_rready,
    input  axi_arready, axi_rdata, axi_rid, axi_rresp, axi_rlast, axi_rvalid
  );

  modport slave (
    input  axi_araddr, axi_arid, axi_arlen, axi_arsize, axi_arburst, axi_arlock, axi_arqos,
    input  axi_arvalid, axi_rready,
    output axi_arready, axi_rdata, axi_rid, axi_rresp, axi_rlast, axi_rvalid
  );
endinterface

// File: rtl/test_rd_ctrl_check_64bit.sv
// DDR3 test-path read initiator: one INCR burst per read_en, each 64-bit beat checked against
// the write test pattern. Optional first-error capture ports under RD_ERR_CAPTURE_EN.
module test_rd_ctrl_check_64bit #(
  parameter int CTRL_ADDR_WIDTH = 28,
  parameter int ERR_CNT_WIDTH   = 16,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       read_en,
  input  logic [CTRL_ADDR_WIDTH-1:0] random_rw_addr,
  input  logic [3:0]                 random_axi_id,
  input  logic [3:0]                 random_axi_len,
  input  logic                       data_pattern_01,
  output logic                       read_done_p,
  output logic                       err_flag,
  output logic [ERR_CNT_WIDTH-1:0]   err_cnt,
  output logic [1:0]                 dbg_state,
  test_rd_ctrl_check_64bit_if.master axi
`ifdef RD_ERR_CAPTURE_EN
  ,
  output logic [63:0]                err_first_data,
  output logic [63:0]                err_first_exp,
  output logic [7:0]                 err_first_addr
`endif
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [63:0] PAT_01 = 64'h0000_FFFF_0000_FFFF;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ADDR = 2'd1, S_DATA = 2'd2, S_CHK = 2'd3} state_t;

  state_t state_q, state_d;
  logic [31:0] araddr_q, araddr_d;
  logic [7:0]  arid_q, arid_d, arlen_q, arlen_d;
  logic [2:0]  arsize_q, arsize_d;
  logic [1:0]  arburst_q, arburst_d;
  logic        arvalid_q, arvalid_d;
  logic        mode_q, mode_d;
  logic [7:0]  base_q, base_d, beat_q, beat_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic        stg_vld_q, stg_vld_d, stg_proto_q, stg_proto_d, stg_tmo_q, stg_tmo_d;
  logic        stg_mode_q, stg_mode_d;
  logic [63:0] stg_data_q, stg_data_d, stg_exp_q, stg_exp_d;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic        err_flag_q, err_flag_d, done_q, done_d;

  logic        rready, beat_fire, last_fire, tmo_hit, data_fail, beat_bad;
  logic [7:0]  a8_cur;
  logic [63:0] exp_cur;
  logic [1:0]  ev_cnt;
  logic [ERR_CNT_WIDTH:0] cnt_sum;

  assign beat_fire = axi.axi_rvalid && rready;
  assign last_fire = beat_fire && axi.axi_rlast;
  assign tmo_hit   = (tmo_q == TMO_LAST) && !last_fire;
  assign a8_cur    = base_q + (beat_q << 2);
  assign exp_cur   = mode_q ? PAT_01
                            : {8'h00, a8_cur + 8'd3, 8'h00, a8_cur + 8'd2,
                               8'h00, a8_cur + 8'd1, 8'h00, a8_cur};

  // Judge stage: mode 0 only constrains hi^lo per lane, so scrambled hi bytes still pass.
  always_comb begin
    data_fail = 1'b0;
    if (stg_mode_q) begin
      data_fail = (stg_data_q != stg_exp_q);
    end else begin
      for (int i = 0; i < 4; i++) begin
        if ((stg_data_q[16*i+8 +: 8] ^ stg_data_q[16*i +: 8]) != stg_exp_q[16*i +: 8])
          data_fail = 1'b1;
      end
    end
  end

  assign beat_bad = stg_vld_q && (data_fail || stg_proto_q);
  assign ev_cnt   = {1'b0, beat_bad} + {1'b0, stg_tmo_q};
  assign cnt_sum  = {1'b0, err_cnt_q} + (ERR_CNT_WIDTH + 1)'(ev_cnt);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (read_en) state_d = S_ADDR;
      S_ADDR: if (arvalid_q && axi.axi_arready) state_d = S_DATA;
      S_DATA: if (last_fire || tmo_hit) state_d = S_CHK;
      S_CHK:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs and datapath next values
  always_comb begin
    rready      = (state_q == S_DATA);
    araddr_d    = araddr_q;
    arid_d      = arid_q;
    arlen_d     = arlen_q;
    arsize_d    = arsize_q;
    arburst_d   = arburst_q;
    arvalid_d   = arvalid_q;
    mode_d      = mode_q;
    base_d      = base_q;
    beat_d      = beat_q;
    tmo_d       = tmo_q;
    stg_vld_d   = 1'b0;
    stg_tmo_d   = 1'b0;
    stg_proto_d = 1'b0;
    stg_mode_d  = mode_q;
    stg_data_d  = axi.axi_rdata;
    stg_exp_d   = exp_cur;
    done_d      = (state_q == S_CHK);
    err_cnt_d   = cnt_sum[ERR_CNT_WIDTH] ? '1 : cnt_sum[ERR_CNT_WIDTH-1:0];
    err_flag_d  = err_flag_q || (ev_cnt != 2'd0);
    case (state_q)
      S_IDLE: if (read_en) begin
        araddr_d  = {{(31-CTRL_ADDR_WIDTH){1'b0}}, random_rw_addr, 1'b0};
        arid_d    = {4'b0, random_axi_id};
        arlen_d   = {4'b0, random_axi_len};
        arsize_d  = 3'b011;
        arburst_d = 2'b01;
        arvalid_d = 1'b1;
        mode_d    = data_pattern_01;
        base_d    = random_rw_addr[7:0];
      end
      S_ADDR: if (arvalid_q && axi.axi_arready) begin
        arvalid_d = 1'b0;
        beat_d    = 8'd0;
        tmo_d     = '0;
      end
      S_DATA: begin
        tmo_d     = tmo_q + 1'b1;
        stg_vld_d = beat_fire;
        stg_tmo_d = tmo_hit;
        if (beat_fire) beat_d = beat_q + 8'd1;
        stg_proto_d = (axi.axi_rid != arid_q) || (axi.axi_rresp != 2'b00) ||
                      (axi.axi_rlast != (beat_q == arlen_q));
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      araddr_q <= '0; arid_q <= '0; arlen_q <= '0; arsize_q <= '0; arburst_q <= '0;
      arvalid_q <= 1'b0; mode_q <= 1'b0; base_q <= '0; beat_q <= '0; tmo_q <= '0;
      stg_vld_q <= 1'b0; stg_proto_q <= 1'b0; stg_tmo_q <= 1'b0; stg_mode_q <= 1'b0;
      stg_data_q <= '0; stg_exp_q <= '0;
      err_cnt_q <= '0; err_flag_q <= 1'b0; done_q <= 1'b0;
    end else begin
      araddr_q <= araddr_d; arid_q <= arid_d; arlen_q <= arlen_d; arsize_q <= arsize_d;
      arburst_q <= arburst_d; arvalid_q <= arvalid_d; mode_q <= mode_d; base_q <= base_d;
      beat_q <= beat_d; tmo_q <= tmo_d;
      stg_vld_q <= stg_vld_d; stg_proto_q <= stg_proto_d; stg_tmo_q <= stg_tmo_d;
      stg_mode_q <= stg_mode_d; stg_data_q <= stg_data_d; stg_exp_q <= stg_exp_d;
      err_cnt_q <= err_cnt_d; err_flag_q <= err_flag_d; done_q <= done_d;
    end
  end

`ifdef RD_ERR_CAPTURE_EN
  logic [7:0]  stg_a8_q, stg_a8_d;
  logic [63:0] cap_data_q, cap_data_d, cap_exp_q, cap_exp_d;
  logic [7:0]  cap_addr_q, cap_addr_d;

  always_comb begin
    stg_a8_d   = a8_cur;
    cap_data_d = cap_data_q;
    cap_exp_d  = cap_exp_q;
    cap_addr_d = cap_addr_q;
    if (!err_flag_q && (ev_cnt != 2'd0)) begin
      cap_data_d = stg_data_q;
      cap_exp_d  = stg_exp_q;
      cap_addr_d = stg_a8_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_a8_q <= '0; cap_data_q <= '0; cap_exp_q <= '0; cap_addr_q <= '0;
    end else begin
      stg_a8_q <= stg_a8_d; cap_data_q <= cap_data_d; cap_exp_q <= cap_exp_d;
      cap_addr_q <= cap_addr_d;
    end
  end

  assign err_first_data = cap_data_q;
  assign err_first_exp  = cap_exp_q;
  assign err_first_addr = cap_addr_q;
`endif

  assign axi.axi_araddr  = araddr_q;
  assign axi.axi_arid    = arid_q;
  assign axi.axi_arlen   = arlen_q;
  assign axi.axi_arsize  = arsize_q;
  assign axi.axi_arburst = arburst_q;
  assign axi.axi_arlock  = 1'b0;
  assign axi.axi_arqos   = 4'h0;
  assign axi.axi_arvalid = arvalid_q;
  assign axi.axi_rready  = rready;
  assign read_done_p     = done_q;
  assign err_flag        = err_flag_q;
  assign err_cnt         = err_cnt_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_test_rd_ctrl_check_64bit.sv
// Directed bench for test_rd_ctrl_check_64bit: table of bursts plus timeout and mid-burst reset.
module tb_test_rd_ctrl_check_64bit;
  localparam int TMO = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        read_en = 1'b0;
  logic [27:0] random_rw_addr = '0;
  logic [3:0]  random_axi_id = '0;
  logic [3:0]  random_axi_len = '0;
  logic        data_pattern_01 = 1'b0;
  logic        read_done_p, err_flag;
  logic [15:0] err_cnt;
  logic [1:0]  dbg_state;
`ifdef RD_ERR_CAPTURE_EN
  logic [63:0] err_first_data, err_first_exp;
  logic [7:0]  err_first_addr;
`endif

  test_rd_ctrl_check_64bit_if axi();

  test_rd_ctrl_check_64bit #(.CTRL_ADDR_WIDTH(28), .ERR_CNT_WIDTH(16), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .read_en(read_en), .random_rw_addr(random_rw_addr),
    .random_axi_id(random_axi_id), .random_axi_len(random_axi_len),
    .data_pattern_01(data_pattern_01), .read_done_p(read_done_p), .err_flag(err_flag),
    .err_cnt(err_cnt), .dbg_state(dbg_state), .axi(axi.master)
`ifdef RD_ERR_CAPTURE_EN
    , .err_first_data(err_first_data), .err_first_exp(err_first_exp),
    .err_first_addr(err_first_addr)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  typedef struct {
    logic [27:0] addr;
    logic [3:0]  id;
    logic [3:0]  len;
    logic        mode;
    int          bad_beat;
    logic [63:0] mask;
    logic        rid_bad;
    logic [1:0]  rresp;
    int          last_beat;
    int          n_beats;
    int          exp_err;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] good_data(input logic [7:0] base, input int b, input logic mode);
    logic [7:0]  a8, hi;
    logic [63:0] d;
    d = '0;
    if (mode) return 64'h0000_FFFF_0000_FFFF;
    a8 = base + 8'(4 * b);
    for (int i = 0; i < 4; i++) begin
      hi = 8'($urandom_range(0, 255));
      d[16*i+8 +: 8] = hi;
      d[16*i +: 8]   = hi ^ (a8 + 8'(i));
    end
    return d;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    read_en = 1'b0;
    axi.axi_arready = 1'b0; axi.axi_rvalid = 1'b0; axi.axi_rlast = 1'b0;
    axi.axi_rdata = '0; axi.axi_rid = '0; axi.axi_rresp = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_arvalid", 64'(axi.axi_arvalid), 64'd0);
    chk("rst_rready", 64'(axi.axi_rready), 64'd0);
    chk("rst_done", 64'(read_done_p), 64'd0);
    chk("rst_err", {47'd0, err_flag, err_cnt}, 64'd0);
    chk("rst_araddr", 64'(axi.axi_araddr), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // driver: issue read_en, stall AR one cycle, check AR payload stays put, then accept
  task automatic start_burst(input logic [27:0] addr, input logic [3:0] id,
                             input logic [3:0] len, input logic mode);
    random_rw_addr = addr; random_axi_id = id; random_axi_len = len; data_pattern_01 = mode;
    read_en = 1'b1;
    @(posedge clk); #1;
    read_en = 1'b0;
    chk("ar_valid", 64'(axi.axi_arvalid), 64'd1);
    chk("ar_addr", 64'(axi.axi_araddr), 64'(addr) << 1);
    chk("ar_id_len", {48'd0, axi.axi_arid, axi.axi_arlen}, {52'd0, id, 4'h0, len});
    chk("ar_size_burst", {59'd0, axi.axi_arsize, axi.axi_arburst}, 64'b01101);
    random_rw_addr = ~addr; random_axi_id = ~id; random_axi_len = ~len;
    @(posedge clk); #1;
    chk("ar_stable", {24'd0, axi.axi_araddr, axi.axi_arlen}, {24'd0, 32'(addr) << 1, 4'h0, len});
    axi.axi_arready = 1'b1;
    @(posedge clk); #1;
    axi.axi_arready = 1'b0;
    chk("ar_done", {62'd0, axi.axi_arvalid, axi.axi_rready}, 64'b01);
  endtask

  task automatic run_vec(input int k, input vec_t v);
    int pulses;
    logic [63:0] exp_err;
    exp_q.push_back(64'(v.exp_err));
    do_reset();
    start_burst(v.addr, v.id, v.len, v.mode);
    read_en = 1'b1;
    for (int b = 0; b < v.n_beats; b++) begin
      axi.axi_rvalid = 1'b1;
      axi.axi_rdata  = good_data(v.addr[7:0], b, v.mode) ^ ((b == v.bad_beat) ? v.mask : 64'd0);
      axi.axi_rid    = {4'h0, v.id} | (v.rid_bad ? 8'h80 : 8'h00);
      axi.axi_rresp  = v.rresp;
      axi.axi_rlast  = (b == v.last_beat);
      @(posedge clk); #1;
      axi.axi_rvalid = 1'b0;
      axi.axi_rlast  = 1'b0;
      if (b == v.n_beats - 1) read_en = 1'b0;
      if (b == v.bad_beat) begin
        chk($sformatf("v%0d_err_lat1", k), 64'(err_cnt), 64'd0);
        @(posedge clk); #1;
        chk($sformatf("v%0d_err_lat2", k), 64'(err_cnt), 64'd1);
      end else if ((b % 2) == 1 && b != v.n_beats - 1) begin
        @(posedge clk); #1;
      end
    end
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      if (read_done_p) pulses++;
      @(posedge clk); #1;
    end
    exp_err = exp_q.pop_front();
    chk($sformatf("v%0d_done_pulses", k), 64'(pulses), 64'd1);
    chk($sformatf("v%0d_err_cnt", k), 64'(err_cnt), exp_err);
    chk($sformatf("v%0d_err_flag", k), 64'(err_flag), 64'(exp_err != 0));
    chk($sformatf("v%0d_idle", k), {61'd0, axi.axi_arvalid, dbg_state}, 64'd0);
  endtask

  initial begin
    int cyc;
    int pulses;
    vecs[0] = '{28'h10,      4'h5, 4'd3,  1'b0, -1, 64'h0,                   1'b0, 2'b00, 3,  4,  0};
    vecs[1] = '{28'h10,      4'h5, 4'd3,  1'b0,  2, 64'h0000_0000_00FF_0000, 1'b0, 2'b00, 3,  4,  1};
    vecs[2] = '{28'h0,       4'h2, 4'd0,  1'b1, -1, 64'h0,                   1'b0, 2'b00, 0,  1,  0};
    vecs[3] = '{28'h0,       4'h2, 4'd0,  1'b1,  0, 64'h0000_FFFF_0000_FFFF, 1'b0, 2'b00, 0,  1,  1};
    vecs[4] = '{28'hFC,      4'h7, 4'd2,  1'b0, -1, 64'h0,                   1'b0, 2'b00, 2,  3,  0};
    vecs[5] = '{28'h40,      4'h3, 4'd3,  1'b0, -1, 64'h0,                   1'b1, 2'b00, 1,  2,  2};
    vecs[6] = '{28'h20,      4'h1, 4'd1,  1'b0, -1, 64'h0,                   1'b0, 2'b10, 1,  2,  2};
    vecs[7] = '{28'h30,      4'h9, 4'd1,  1'b0, -1, 64'h0,                   1'b0, 2'b00, 2,  3,  2};
    vecs[8] = '{28'hABCDEF1, 4'hF, 4'd15, 1'b0, -1, 64'h0,                   1'b0, 2'b00, 15, 16, 0};

    for (int k = 0; k < 9; k++) begin
      run_vec(k, vecs[k]);
`ifdef RD_ERR_CAPTURE_EN
      if (k == 1) chk("cap_addr", 64'(err_first_addr), 64'h18);
`endif
    end

    // timeout: AR accepted, no R beats ever arrive
    do_reset();
    start_burst(28'h50, 4'h4, 4'd3, 1'b0);
    cyc = 0;
    while (!read_done_p && cyc < 2 * TMO) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("tmo_cycles", 64'(cyc), 64'(TMO + 1));
    chk("tmo_err", {47'd0, err_flag, err_cnt}, {47'd0, 1'b1, 16'd1});
    @(posedge clk); #1;
    chk("tmo_pulse_1cyc", 64'(read_done_p), 64'd0);

    // reset mid-burst: burst is abandoned with no done pulse
    do_reset();
    start_burst(28'h60, 4'h6, 4'd3, 1'b0);
    axi.axi_rvalid = 1'b1; axi.axi_rid = 8'h06; axi.axi_rresp = 2'b00;
    axi.axi_rdata = good_data(8'h60, 0, 1'b0);
    @(posedge clk); #1;
    axi.axi_rvalid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_outs", {61'd0, axi.axi_arvalid, axi.axi_rready, read_done_p}, 64'd0);
    chk("midrst_state", 64'(dbg_state), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (read_done_p) pulses++;
    end
    chk("midrst_no_pulse", 64'(pulses), 64'd0);
    chk("midrst_err", {47'd0, err_flag, err_cnt}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
